multi_cycle_control_unit: RTL and testbench
===========================================

Name: multi_cycle_control_unit

Overview:
Moore FSM that sequences the shared multi-cycle RV32I datapath: PC, IR, MDR, ALUOut, register file, single ALU, unified memory and the immediate generator. Each instruction advances through IF/ID/EX/MEM/WB as its opcode requires. The block drives every datapath enable and mux select. It stalls on a memory ready handshake and retires ECALL-halt. It also keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
OPCODE_W, 7, opcode field width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
opcode  in  OPCODE_W  IR[6:0], valid from ID onward
bcond  in  1  ALU branch-compare result (valid in EX for BRANCH)
is_halt_cond  in  1  high when x17==10 (ECALL halt condition), sampled in ID
mem_ready  in  1  memory completes current access this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  address select: 0=PC, 1=ALUOut
ir_write  out  1  load IR from memory data
reg_write  out  1  register file write
wb_sel  out  2  rd source: 0=ALUOut, 1=MDR, 2=PC+4 adder
alu_src_a  out  2  0=PC, 1=rs1, 2=zero
alu_src_b  out  2  0=rs2, 1=constant 4, 2=immediate
alu_op  out  2  0=ADD, 1=FUNCT-decoded, 2=BRANCH compare
pc_write  out  1  PC load enable
pc_source  out  1  0=ALU result (combinational), 1=ALUOut register
state  out  3  current state, for debug
halted  out  1  CPU halted
num_inst  out  CNT_W  retired instruction count
illegal_inst  out  1  one-cycle pulse, unknown opcode in ID

Behaviour:
- Reset (reset=0, async): state=IF, num_inst=0, halted=0. All outputs take their IF-state values once reset is released.
- Default output value is 0 unless listed for a state.
- IF (0): mem_read=1, i_or_d=0, ir_write=mem_ready.
  - Stays in IF while mem_ready=0. IR loads only in the cycle mem_ready=1.
  - Goes to ID when mem_ready=1.
- ID (1): a=PC, b=imm, ADD. ALUOut captures PC+imm, the branch/JAL target.
  - ECALL with is_halt_cond=1 -> HALT; num_inst increments.
  - ECALL with is_halt_cond=0 -> WB.
  - Unknown opcode -> illegal_inst=1 -> WB. The instruction is treated as a NOP.
  - Otherwise -> EX.
- EX (2), per opcode:
  - R-type: a=rs1, b=rs2, FUNCT -> WB.
  - I-arith: a=rs1, b=imm, FUNCT -> WB.
  - LOAD/STORE: a=rs1, b=imm, ADD -> MEM.
  - LUI: a=zero, b=imm, ADD -> WB.
  - AUIPC: a=PC, b=imm, ADD -> WB.
  - BRANCH: a=rs1, b=rs2, BRANCH compare.
    - bcond=1: pc_write=1, pc_source=1, retire -> IF.
    - bcond=0: -> WB for PC+4.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_source=1, retire -> IF.
  - JALR: a=rs1, b=imm, ADD; reg_write=1, wb_sel=2, pc_write=1, pc_source=0 (datapath clears bit 0); retire -> IF.
- MEM (3): i_or_d=1.
  - LOAD: mem_read=1. STORE: mem_write=1.
  - Holds while mem_ready=0, with requests held stable.
  - On mem_ready: LOAD -> WB. STORE -> WB with reg_write=0.
  - MDR captures memory data every cycle; this needs no control.
- WB (4): a=PC, b=4, ADD, pc_write=1, pc_source=0, retire -> IF.
  - reg_write=1 only for R, I-arith, LOAD, LUI, AUIPC.
  - wb_sel=1 for LOAD, 0 otherwise.
- HALT (5): halted=1, all enables 0. Absorbing state; only reset leaves it.
- Retire: num_inst increments by 1 on the same edge as the retiring PC write (or on HALT entry). Wraps modulo 2^CNT_W.
- Latency: R/I/LUI/AUIPC 4 cycles; LOAD 5; STORE 5; branch 3 (taken) or 4 (not taken); JAL/JALR 3. Each memory wait cycle adds 1.
- Reset asserted mid-instruction forces IF immediately, with no partial retire.
- States 6 and 7 are unreachable. If entered, the FSM goes to IF on the next cycle.

Decomposition:
- Opcode constants come from the shared opcode include file.
- A shared constants include holds:
  - state encodings;
  - wb_sel, alu_src_a/b, alu_op and pc_source encodings, so the datapath muxes use identical values.
- One natural sub-module: control_output_decoder, the combinational map from (state, opcode, bcond, mem_ready) to outputs. The top level holds the state register, next-state logic and counter.

Test Plan:
- ADD x3,x1,x2 with mem_ready always 1 -> states IF,ID,EX,WB. reg_write=1 and pc_write=1 in cycle 4. num_inst goes 0->1.
- LW with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles with mem_read=1, i_or_d=1. WB has wb_sel=1. Total 7 cycles.
- BEQ, first with bcond=1 then bcond=0 -> taken case: pc_write=1, pc_source=1 in EX, 3 cycles. Not-taken case: pc_write in WB with pc_source=0, 4 cycles.
- JALR -> EX has reg_write=1, wb_sel=2, pc_write=1, pc_source=0. Next state is IF.
- ECALL with is_halt_cond=1 -> HALT after ID; halted=1, num_inst+1. A later mem_ready toggle causes no transitions.
- Assert reset low during MEM of a SW -> state=IF and num_inst=0 immediately. After release, mem_read=1 and mem_write=0.

Source files
------------

// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit and its datapath:
// state codes, mux select values, opcodes and the packed control word.
package multi_cycle_control_unit_pkg;

  localparam int OPCODE_W_DEF = 7;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] SRC_A_PC   = 2'd0;
  localparam logic [1:0] SRC_A_RS1  = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_FUNCT  = 2'd1;
  localparam logic [1:0] ALU_BRANCH = 2'd2;

  localparam logic PC_SRC_ALU    = 1'b0;
  localparam logic PC_SRC_ALUOUT = 1'b1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       pc_source;
    logic       halted;
    logic       illegal_inst;
  } ctrl_t;

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC,
      OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // Opcodes whose WB cycle writes rd (jumps write rd in EX instead).
  function automatic logic writes_rd_in_wb(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit (master) and the
// shared datapath/memory (slave).
interface multi_cycle_control_unit_if #(
  parameter int OPCODE_W = 7
);
  logic [OPCODE_W-1:0] opcode;
  logic                bcond;
  logic                is_halt_cond;
  // Memory handshake: mem_read/mem_write act as valid and stay stable, with
  // i_or_d, until the cycle mem_ready (ready) is high; that cycle completes it.
  logic                mem_ready;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                ir_write;
  logic                reg_write;
  logic [1:0]          wb_sel;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          alu_op;
  logic                pc_write;
  logic                pc_source;

  modport master (
    input  opcode, bcond, is_halt_cond, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_source
  );

  modport slave (
    output opcode, bcond, is_halt_cond, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op, pc_write, pc_source
  );
endinterface

// File: rtl/multi_cycle_control_unit_decoder.sv
// Combinational map from (state, opcode, bcond, mem_ready) to the datapath
// control word; every field defaults to 0.
module control_output_decoder
  import multi_cycle_control_unit_pkg::*;
(
  input  state_t     state,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b0;
        ctrl.ir_write = mem_ready;
      end
      S_ID: begin
        // ALUOut captures PC+imm, used later as branch/JAL target.
        ctrl.alu_src_a    = SRC_A_PC;
        ctrl.alu_src_b    = SRC_B_IMM;
        ctrl.alu_op       = ALU_ADD;
        ctrl.illegal_inst = !is_known_opcode(opcode);
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_I: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_LUI: begin
            ctrl.alu_src_a = SRC_A_ZERO;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_AUIPC: begin
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_RS2;
            ctrl.alu_op    = ALU_BRANCH;
            if (bcond) begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = PC_SRC_ALUOUT;
            end
          end
          OP_JAL: begin
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALUOUT;
          end
          OP_JALR: begin
            // Target comes straight off the ALU; datapath clears bit 0.
            ctrl.alu_src_a = SRC_A_RS1;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = ALU_ADD;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC4;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PC_SRC_ALU;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LOAD);
        ctrl.mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.reg_write = writes_rd_in_wb(opcode);
        ctrl.wb_sel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Moore control FSM for the shared multi-cycle RV32I datapath: state
// register, next-state logic and the retired-instruction counter.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int OPCODE_W = OPCODE_W_DEF
)(
  input  logic                        clk,
  input  logic                        reset,
  multi_cycle_control_unit_if.master  bus,
  output logic [2:0]                  state,
  output logic                        halted,
  output logic [CNT_W-1:0]            num_inst,
  output logic                        illegal_inst
);

  state_t              state_q, state_d;
  ctrl_t               ctrl;
  logic [OPCODE_W-1:0] opcode;
  logic [6:0]          op;
  logic                retire;

  assign opcode = bus.opcode;
  assign op     = opcode[6:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (bus.mem_ready) state_d = S_ID;
      S_ID: begin
        if (op == OP_SYSTEM)           state_d = bus.is_halt_cond ? S_HALT : S_WB;
        else if (!is_known_opcode(op)) state_d = S_WB;
        else                           state_d = S_EX;
      end
      S_EX: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH:         state_d = bus.bcond ? S_IF : S_WB;
          OP_JAL, OP_JALR:   state_d = S_IF;
          default:           state_d = S_WB;
        endcase
      end
      S_MEM:  if (bus.mem_ready) state_d = S_WB;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  control_output_decoder u_decoder (
    .state     (state_q),
    .opcode    (op),
    .bcond     (bus.bcond),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  // Every retiring path writes the PC, except the halting ECALL.
  assign retire = ctrl.pc_write || ((state_q == S_ID) && (state_d == S_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      num_inst <= '0;
    else if (retire) num_inst <= num_inst + 1'b1;
  end

  assign bus.mem_read  = ctrl.mem_read;
  assign bus.mem_write = ctrl.mem_write;
  assign bus.i_or_d    = ctrl.i_or_d;
  assign bus.ir_write  = ctrl.ir_write;
  assign bus.reg_write = ctrl.reg_write;
  assign bus.wb_sel    = ctrl.wb_sel;
  assign bus.alu_src_a = ctrl.alu_src_a;
  assign bus.alu_src_b = ctrl.alu_src_b;
  assign bus.alu_op    = ctrl.alu_op;
  assign bus.pc_write  = ctrl.pc_write;
  assign bus.pc_source = ctrl.pc_source;

  assign state        = state_q;
  assign halted       = ctrl.halted;
  assign illegal_inst = ctrl.illegal_inst;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-cycle expected control snapshots
// queued with the stimulus and compared against the DUT each cycle.
module tb_multi_cycle_control_unit;

  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011, LUI_OP = 7'b0110111, AUI_OP = 7'b0010111;
  localparam logic [6:0] BR_OP = 7'b1100011, JAL_OP = 7'b1101111, JALR_OP = 7'b1100111;
  localparam logic [6:0] SYS_OP = 7'b1110011, BAD_OP = 7'b0001111;

  localparam logic [1:0] A_PC = 2'd0, A_RS1 = 2'd1, A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2 = 2'd0, B_FOUR = 2'd1, B_IMM = 2'd2;
  localparam logic [1:0] F_ADD = 2'd0, F_FUNCT = 2'd1, F_BR = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_cycle_control_unit_if #(.OPCODE_W(7)) bus ();
  logic [2:0]  state;
  logic        halted;
  logic [31:0] num_inst;
  logic        illegal_inst;

  multi_cycle_control_unit #(.CNT_W(32), .OPCODE_W(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .state        (state),
    .halted       (halted),
    .num_inst     (num_inst),
    .illegal_inst (illegal_inst)
  );

  logic [19:0] obs;
  assign obs = {state, bus.mem_read, bus.mem_write, bus.i_or_d, bus.ir_write,
                bus.reg_write, bus.wb_sel, bus.alu_src_a, bus.alu_src_b,
                bus.alu_op, bus.pc_write, bus.pc_source, halted, illegal_inst};

  // scoreboard
  logic [19:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] snap(input logic [2:0] st, input logic rd, input logic wr,
      input logic iod, input logic irw, input logic rw, input logic [1:0] wbs,
      input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
      input logic pcw, input logic pcs, input logic hlt, input logic ill);
    return {st, rd, wr, iod, irw, rw, wbs, a, b, op, pcw, pcs, hlt, ill};
  endfunction

  function automatic logic [19:0] exp_if(input logic rdy);
    return snap(3'd0, 1, 0, 0, rdy, 0, 2'd0, A_PC, B_RS2, F_ADD, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] exp_id(input logic ill);
    return snap(3'd1, 0, 0, 0, 0, 0, 2'd0, A_PC, B_IMM, F_ADD, 0, 0, 0, ill);
  endfunction
  function automatic logic [19:0] exp_ex(input logic [1:0] a, input logic [1:0] b,
      input logic [1:0] op, input logic rw, input logic [1:0] wbs, input logic pcw, input logic pcs);
    return snap(3'd2, 0, 0, 0, 0, rw, wbs, a, b, op, pcw, pcs, 0, 0);
  endfunction
  function automatic logic [19:0] exp_mem(input logic ld);
    return snap(3'd3, ld, !ld, 1, 0, 0, 2'd0, A_PC, B_RS2, F_ADD, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] exp_wb(input logic rw, input logic [1:0] wbs);
    return snap(3'd4, 0, 0, 0, 0, rw, wbs, A_PC, B_FOUR, F_ADD, 1, 0, 0, 0);
  endfunction
  function automatic logic [19:0] exp_halt();
    return snap(3'd5, 0, 0, 0, 0, 0, 2'd0, A_PC, B_RS2, F_ADD, 0, 0, 1, 0);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [6:0] rnd_op();
    return 7'($urandom_range(0, 127));
  endfunction

  // driver: one clock cycle with expectation pushed alongside the stimulus
  task automatic cyc(input string tag, input logic [19:0] e, input logic rdy,
                     input logic bc, input logic hc, input logic [6:0] op);
    logic [19:0] want;
    exp_q.push_back(e);
    bus.mem_ready    = rdy;
    bus.bcond        = bc;
    bus.is_halt_cond = hc;
    bus.opcode       = op;
    @(negedge clk);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check(tag, {12'd0, obs}, {12'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input int waits);
    for (int i = 0; i < waits; i++) cyc({tag, "_ifw"}, exp_if(0), 0, rb(), rb(), rnd_op());
    cyc({tag, "_if"}, exp_if(1), 1, rb(), rb(), rnd_op());
  endtask

  task automatic retired(input string tag);
    exp_cnt = exp_cnt + 1;
    check({tag, "_num_inst"}, num_inst, exp_cnt);
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input int waits,
                         input logic [19:0] ex_e);
    fetch(tag, waits);
    cyc({tag, "_id"}, exp_id(0), rb(), rb(), rb(), op);
    cyc({tag, "_ex"}, ex_e, rb(), rb(), rb(), op);
    cyc({tag, "_wb"}, exp_wb(1, 2'd0), rb(), rb(), rb(), op);
    retired(tag);
  endtask

  task automatic run_mem(input string tag, input logic ld, input int mem_waits);
    logic [6:0] op;
    op = ld ? LD_OP : ST_OP;
    fetch(tag, 0);
    cyc({tag, "_id"}, exp_id(0), rb(), rb(), rb(), op);
    cyc({tag, "_ex"}, exp_ex(A_RS1, B_IMM, F_ADD, 0, 2'd0, 0, 0), rb(), rb(), rb(), op);
    for (int i = 0; i < mem_waits; i++) cyc({tag, "_memw"}, exp_mem(ld), 0, rb(), rb(), op);
    cyc({tag, "_mem"}, exp_mem(ld), 1, rb(), rb(), op);
    cyc({tag, "_wb"}, exp_wb(ld, ld ? 2'd1 : 2'd0), rb(), rb(), rb(), op);
    retired(tag);
  endtask

  task automatic run_short(input string tag, input logic [6:0] op, input logic bc,
                           input logic [19:0] ex_e);
    fetch(tag, 0);
    cyc({tag, "_id"}, exp_id(0), rb(), rb(), rb(), op);
    cyc({tag, "_ex"}, ex_e, rb(), bc, rb(), op);
    retired(tag);
  endtask

  task automatic run_to_wb(input string tag, input logic [6:0] op, input logic ill);
    fetch(tag, 0);
    cyc({tag, "_id"}, exp_id(ill), rb(), rb(), 0, op);
    cyc({tag, "_wb"}, exp_wb(0, 2'd0), rb(), rb(), rb(), op);
    retired(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mem_ready = 0; bus.bcond = 0; bus.is_halt_cond = 0; bus.opcode = 7'd0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_num_inst", num_inst, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    run_alu("add", R_OP, 0, exp_ex(A_RS1, B_RS2, F_FUNCT, 0, 2'd0, 0, 0));
    run_mem("lw", 1, 2);
    run_alu("addi", I_OP, 1, exp_ex(A_RS1, B_IMM, F_FUNCT, 0, 2'd0, 0, 0));

    run_short("beq_t", BR_OP, 1, exp_ex(A_RS1, B_RS2, F_BR, 0, 2'd0, 1, 1));
    fetch("beq_nt", 0);
    cyc("beq_nt_id", exp_id(0), rb(), rb(), rb(), BR_OP);
    cyc("beq_nt_ex", exp_ex(A_RS1, B_RS2, F_BR, 0, 2'd0, 0, 0), rb(), 0, rb(), BR_OP);
    cyc("beq_nt_wb", exp_wb(0, 2'd0), rb(), rb(), rb(), BR_OP);
    retired("beq_nt");

    run_short("jal", JAL_OP, rb(), exp_ex(A_PC, B_RS2, F_ADD, 1, 2'd2, 1, 1));
    run_short("jalr", JALR_OP, rb(), exp_ex(A_RS1, B_IMM, F_ADD, 1, 2'd2, 1, 0));
    run_alu("lui", LUI_OP, 0, exp_ex(A_ZERO, B_IMM, F_ADD, 0, 2'd0, 0, 0));
    run_alu("auipc", AUI_OP, 0, exp_ex(A_PC, B_IMM, F_ADD, 0, 2'd0, 0, 0));
    run_mem("sw", 0, 1);
    run_to_wb("illegal", BAD_OP, 1);
    run_to_wb("ecall_nh", SYS_OP, 0);

    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0: run_alu("r_rnd", R_OP, $urandom_range(0, 2), exp_ex(A_RS1, B_RS2, F_FUNCT, 0, 2'd0, 0, 0));
        1: run_alu("i_rnd", I_OP, $urandom_range(0, 2), exp_ex(A_RS1, B_IMM, F_FUNCT, 0, 2'd0, 0, 0));
        2: run_alu("lui_rnd", LUI_OP, $urandom_range(0, 2), exp_ex(A_ZERO, B_IMM, F_ADD, 0, 2'd0, 0, 0));
        default: run_alu("aui_rnd", AUI_OP, $urandom_range(0, 2), exp_ex(A_PC, B_IMM, F_ADD, 0, 2'd0, 0, 0));
      endcase
    end

    // reset while a store is waiting in MEM
    fetch("sw_rst", 0);
    cyc("sw_rst_id", exp_id(0), rb(), rb(), rb(), ST_OP);
    cyc("sw_rst_ex", exp_ex(A_RS1, B_IMM, F_ADD, 0, 2'd0, 0, 0), rb(), rb(), rb(), ST_OP);
    cyc("sw_rst_mem", exp_mem(0), 0, rb(), rb(), ST_OP);
    bus.mem_ready = 0;
    reset = 1'b0;
    #1;
    check("midrst_state", {29'd0, state}, 32'd0);
    check("midrst_num_inst", num_inst, 32'd0);
    exp_cnt = 0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    run_alu("post_rst", R_OP, 0, exp_ex(A_RS1, B_RS2, F_FUNCT, 0, 2'd0, 0, 0));

    fetch("halt", 0);
    cyc("halt_id", exp_id(0), rb(), rb(), 1, SYS_OP);
    retired("halt");
    for (int i = 0; i < 4; i++) cyc("halt_hold", exp_halt(), 1'(i % 2), rb(), rb(), rnd_op());
    check("halt_num_inst_hold", num_inst, exp_cnt);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
